// File: rtl/pc_pkg.sv
// pc_pkg: MIPS control-flow opcodes and the next-PC source selector shared by the PC sequencer.
package pc_pkg;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] FUNCT_JR = 6'b001000;
   typedef enum logic [2:0] {SEL_SEQ, SEL_BRANCH, SEL_TARGET, SEL_RAS, SEL_JR} next_pc_sel_t;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push while full overwrites the oldest entry and sets a sticky flag.
module pc_ras #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [W-1:0]               i_data,
   output logic [W-1:0]               o_top,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_overflow
);
   localparam int PW = $clog2(DEPTH);
   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_ptr;
   logic [PW:0]   r_count;
   logic          r_ovf;
   logic          w_full;
   assign w_full     = r_count == (PW+1)'(DEPTH);
   assign o_top      = r_mem[r_ptr - 1'b1];
   assign o_count    = r_count;
   assign o_overflow = r_ovf;
   // When full, r_ptr has wrapped onto the oldest slot, so a push naturally overwrites it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ptr   <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else if (i_push) begin
         r_ptr   <= r_ptr + 1'b1;
         r_count <= w_full ? r_count : r_count + 1'b1;
         r_ovf   <= r_ovf | w_full;
      end else if (i_pop && r_count != '0) begin
         r_ptr   <= r_ptr - 1'b1;
         r_count <= r_count - 1'b1;
      end
   end
   always_ff @(posedge clock) begin
      if (i_push) r_mem[r_ptr] <= i_data;
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register with j/jal/jr/beq/bne next-PC selection, stall and return-address stack.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                INC       = 1,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                RAS_DEPTH = 4,
   parameter int                RAS_EN    = 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         stall,
   input  logic [5:0]                   opcode,
   input  logic [5:0]                   funct,
   input  logic                         Branch,
   input  logic                         zero,
   input  logic                         Jump,
   input  logic [ADDR_W-1:0]            targetAddress,
   input  logic [ADDR_W-1:0]            SignExtend,
   input  logic [ADDR_W-1:0]            jr_target,
   output logic [ADDR_W-1:0]            pc,
   output logic [ADDR_W-1:0]            link_addr,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_overflow
);
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_next_pc, w_link, w_branch, w_top;
   logic              w_j, w_jal, w_jr, w_br, w_push, w_pop;
   next_pc_sel_t      w_sel;
   assign w_link    = r_pc + ADDR_W'(INC);
   assign w_branch  = w_link + SignExtend * ADDR_W'(INC);
   assign pc        = r_pc;
   assign link_addr = w_link;
   always_comb begin
      w_j   = opcode == OP_J & Jump;
      w_jal = opcode == OP_JAL & Jump;
      w_jr  = opcode == OP_RTYPE & funct == FUNCT_JR & Jump;
      w_br  = Branch & ((opcode == OP_BEQ & zero) | (opcode == OP_BNE & !zero));
      w_sel = (w_j | w_jal) ? SEL_TARGET :
              w_jr ? ((RAS_EN != 0 && ras_count != '0) ? SEL_RAS : SEL_JR) :
              w_br ? SEL_BRANCH : SEL_SEQ;
      w_next_pc = w_sel == SEL_TARGET ? targetAddress :
                  w_sel == SEL_RAS    ? w_top :
                  w_sel == SEL_JR     ? jr_target :
                  w_sel == SEL_BRANCH ? w_branch : w_link;
      w_push = !stall & w_jal & !w_j;
      w_pop  = !stall & w_sel == SEL_RAS;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_pc <= RESET_PC;
      else if (!stall) r_pc <= w_next_pc;
   end
   pc_ras #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
      .clock      (clock),
      .reset      (reset),
      .i_push     (w_push),
      .i_pop      (w_pop),
      .i_data     (w_link),
      .o_top      (w_top),
      .o_count    (ras_count),
      .o_overflow (ras_overflow)
   );
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of sequencing, branches, stall, jal/jr with RAS, overflow and wrap-around.
module tb_pc_sequencer;
   import pc_pkg::*;
   logic        clock = 1'b0, reset = 1'b1, stall = 1'b0;
   logic        Branch = 1'b0, zero = 1'b0, Jump = 1'b0;
   logic [5:0]  opcode = '0, funct = '0;
   logic [31:0] tgt = '0, se = '0, jrt = '0;
   logic [31:0] pc, link, pc4, link4;
   logic [7:0]  pc8, link8;
   logic [2:0]  cnt, cnt8, cnt4;
   logic        ovf, ovf8, ovf4;
   int          checks = 0, errors = 0;
   always #5 clock = ~clock;
   pc_sequencer #(.ADDR_W(32), .INC(1), .RESET_PC('0), .RAS_DEPTH(4), .RAS_EN(1)) dut (
      .clock(clock), .reset(reset), .stall(stall), .opcode(opcode), .funct(funct),
      .Branch(Branch), .zero(zero), .Jump(Jump), .targetAddress(tgt), .SignExtend(se),
      .jr_target(jrt), .pc(pc), .link_addr(link), .ras_count(cnt), .ras_overflow(ovf));
   pc_sequencer #(.ADDR_W(8), .INC(1), .RESET_PC('0), .RAS_DEPTH(4), .RAS_EN(1)) dut8 (
      .clock(clock), .reset(reset), .stall(stall), .opcode(opcode), .funct(funct),
      .Branch(Branch), .zero(zero), .Jump(Jump), .targetAddress(tgt[7:0]), .SignExtend(se[7:0]),
      .jr_target(jrt[7:0]), .pc(pc8), .link_addr(link8), .ras_count(cnt8), .ras_overflow(ovf8));
   pc_sequencer #(.ADDR_W(32), .INC(4), .RESET_PC('0), .RAS_DEPTH(4), .RAS_EN(1)) dut4 (
      .clock(clock), .reset(reset), .stall(stall), .opcode(opcode), .funct(funct),
      .Branch(Branch), .zero(zero), .Jump(Jump), .targetAddress(tgt), .SignExtend(se),
      .jr_target(jrt), .pc(pc4), .link_addr(link4), .ras_count(cnt4), .ras_overflow(ovf4));
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic ctl(logic [5:0] op, logic [5:0] fn, logic br, logic z, logic jp,
                      logic [31:0] t, logic [31:0] s, logic [31:0] r);
      opcode = op; funct = fn; Branch = br; zero = z; Jump = jp; tgt = t; se = s; jrt = r;
   endtask
   task automatic idle();
      ctl(OP_RTYPE, 6'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
   endtask
   task automatic step();
      @(posedge clock);
      #1;
   endtask
   task automatic jump_to(logic [31:0] a);
      ctl(OP_J, 6'd0, 1'b0, 1'b0, 1'b1, a, 32'd0, 32'd0);
      step();
      idle();
   endtask
   initial begin
      #12 reset = 1'b0;
      chk("reset_pc", pc, 0);
      chk("reset_cnt", 32'(cnt), 0);
      chk("reset_ovf", 32'(ovf), 0);
      for (int i = 1; i <= 5; i++) begin
         step();
         chk("seq_pc", pc, i);
      end
      #2 reset = 1'b1;
      #1 chk("async_reset_pc", pc, 0);
      #2 reset = 1'b0;
      jump_to(10);
      chk("j_to_10", pc, 10);
      ctl(OP_BEQ, 6'd0, 1'b1, 1'b1, 1'b0, 32'd0, -32'sd3, 32'd0);
      step();
      chk("beq_taken", pc, 8);
      jump_to(10);
      ctl(OP_BNE, 6'd0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd5, 32'd0);
      step();
      chk("bne_not_taken", pc, 11);
      jump_to(10);
      ctl(OP_BNE, 6'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd5, 32'd0);
      step();
      chk("bne_taken", pc, 16);
      ctl(OP_BEQ, 6'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd5, 32'd0);
      step();
      chk("beq_not_taken", pc, 17);
      jump_to(7);
      stall = 1'b1;
      ctl(OP_J, 6'd0, 1'b0, 1'b0, 1'b1, 32'd100, 32'd0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_hold", pc, 7);
      end
      stall = 1'b0;
      step();
      chk("stall_release", pc, 100);
      jump_to(20);
      ctl(OP_JAL, 6'd0, 1'b0, 1'b0, 1'b1, 32'd50, 32'd0, 32'd0);
      chk("jal_link", link, 21);
      step();
      chk("jal_pc", pc, 50);
      chk("jal_cnt", 32'(cnt), 1);
      ctl(OP_RTYPE, FUNCT_JR, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd99);
      step();
      chk("jr_ras_pc", pc, 21);
      chk("jr_ras_cnt", 32'(cnt), 0);
      step();
      chk("jr_reg_pc", pc, 99);
      chk("jr_reg_cnt", 32'(cnt), 0);
      jump_to(1);
      for (int a = 2; a <= 6; a++) begin
         ctl(OP_JAL, 6'd0, 1'b0, 1'b0, 1'b1, 32'(a), 32'd0, 32'd0);
         step();
      end
      chk("nest_pc", pc, 6);
      chk("nest_cnt", 32'(cnt), 4);
      chk("nest_ovf", 32'(ovf), 1);
      ctl(OP_RTYPE, FUNCT_JR, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd200);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("pop_pc", pc, 32'(6 - i));
      end
      chk("pop_cnt", 32'(cnt), 0);
      chk("pop_ovf_sticky", 32'(ovf), 1);
      step();
      chk("empty_jr_pc", pc, 200);
      idle();
      #2 reset = 1'b1;
      #1 chk("reset2_pc", pc, 0);
      chk("reset2_ovf", 32'(ovf), 0);
      chk("reset2_cnt", 32'(cnt), 0);
      #2 reset = 1'b0;
      ctl(OP_BEQ, 6'd0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd2, 32'd0);
      step();
      chk("inc4_beq", pc4, 12);
      chk("w8_beq", 32'(pc8), 3);
      jump_to(255);
      chk("w8_at_255", 32'(pc8), 255);
      step();
      chk("w8_wrap", 32'(pc8), 0);
      chk("w32_no_wrap", pc, 256);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
